// File: rtl/sync_param_fifo.sv
// sync_param_fifo: single-clock FIFO with registered occupancy, threshold
// flags and sticky overflow/underflow indicators.
// Optional feature: define FIFO_FWFT_EN for first-word-fall-through output
// (head entry visible on buf_out with zero read latency). Without it,
// buf_out registers the head entry on the edge that accepts a read.
// rst is asynchronous active-low; clr is a synchronous flush.
module sync_param_fifo #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned AF_LEVEL = DEPTH - 4,
   parameter int unsigned AE_LEVEL = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [WIDTH-1:0]         buf_in,
   output logic [WIDTH-1:0]         buf_out,
   output logic                     buf_empty,
   output logic                     buf_full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   fifo_counter,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT  = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT  = CW'(AE_LEVEL);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             rd_acc;
   logic             wr_acc;

   // Accept decisions; a flush in the same cycle suppresses both requests.
   // A write into a full FIFO is allowed only when a read frees a slot,
   // while a write never makes a read of an empty FIFO valid.
   always_comb begin
      rd_acc = 1'b0;
      wr_acc = 1'b0;
      if (!clr) begin
         rd_acc = rd_en && !buf_empty;
         wr_acc = wr_en && (!buf_full || rd_acc);
      end
   end

   // Next-state occupancy, shared by the counter and all status flags.
   always_comb begin
      count_next = fifo_counter;
      if (clr)
         count_next = '0;
      else if (wr_acc && !rd_acc)
         count_next = fifo_counter + CNT_ONE;
      else if (rd_acc && !wr_acc)
         count_next = fifo_counter - CNT_ONE;
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= buf_in;
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_counter <= '0;
      end else if (clr) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_counter <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc)
            rd_ptr <= rd_ptr + PTR_ONE;
         fifo_counter <= count_next;
      end
   end

   // Status flags registered from the next-state count so they line up
   // with fifo_counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_empty    <= 1'b1;
         buf_full     <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         buf_empty    <= (count_next == '0);
         buf_full     <= (count_next == CNT_MAX);
         almost_empty <= (count_next <= AE_CNT);
         almost_full  <= (count_next >= AF_CNT);
      end
   end

   // Sticky error flags; cleared only by reset or flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && !wr_acc)
            overflow <= 1'b1;
         if (rd_en && buf_empty)
            underflow <= 1'b1;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head entry falls through to the output; zero while empty.
   always_comb begin
      buf_out = '0;
      if (!buf_empty)
         buf_out = mem[rd_ptr];
   end
`else
   // Output register loads the head entry only on an accepted read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         buf_out <= '0;
      else if (rd_acc)
         buf_out <= mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_sync_param_fifo.sv
// Self-checking bench for sync_param_fifo (WIDTH=8, DEPTH=64).
// A queue-based reference model tracks contents, sticky flags and the
// expected output; both FIFO_FWFT_EN builds are handled.
module tb_sync_param_fifo;

   localparam int unsigned DEPTH = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] buf_in = '0;
   logic [7:0] buf_out;
   logic       buf_empty, buf_full, almost_empty, almost_full;
   logic [6:0] fifo_counter;
   logic       overflow, underflow;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [7:0] q [$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic [7:0] m_reg_out = '0;

   sync_param_fifo #(
      .WIDTH(8),
      .DEPTH(64),
      .AF_LEVEL(60),
      .AE_LEVEL(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .wr_en(wr_en),
      .rd_en(rd_en),
      .buf_in(buf_in),
      .buf_out(buf_out),
      .buf_empty(buf_empty),
      .buf_full(buf_full),
      .almost_empty(almost_empty),
      .almost_full(almost_full),
      .fifo_counter(fifo_counter),
      .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_out();
`ifdef FIFO_FWFT_EN
      return (q.size() != 0) ? q[0] : 8'h00;
`else
      return m_reg_out;
`endif
   endfunction

   task automatic check_all(input string tag);
      int unsigned n;
      n = q.size();
      check({tag, ".count"}, 32'(fifo_counter), n);
      check({tag, ".empty"}, 32'(buf_empty), 32'(n == 0));
      check({tag, ".full"}, 32'(buf_full), 32'(n == DEPTH));
      check({tag, ".ae"}, 32'(almost_empty), 32'(n <= 4));
      check({tag, ".af"}, 32'(almost_full), 32'(n >= 60));
      check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
      check({tag, ".out"}, 32'(buf_out), 32'(exp_out()));
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_reg_out = '0;
   endtask

   task automatic model_edge(input logic w, input logic r, input logic c, input logic [7:0] d);
      int unsigned sz;
      logic rd_ok, wr_ok;
      sz = q.size();
      if (c) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         rd_ok = r && (sz > 0);
         wr_ok = w && ((sz < DEPTH) || rd_ok);
         if (w && !wr_ok) m_ovf = 1'b1;
         if (r && sz == 0) m_unf = 1'b1;
         if (rd_ok) m_reg_out = q.pop_front();
         if (wr_ok) q.push_back(d);
      end
   endtask

   // One clock: inputs driven at negedge, model advanced at posedge,
   // outputs checked at the following negedge.
   task automatic step(input string tag, input logic w, input logic r, input logic c, input logic [7:0] d);
      wr_en = w; rd_en = r; clr = c; buf_in = d;
      @(posedge clk);
      model_edge(w, r, c, d);
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [7:0] vals [3];
      vals[0] = 8'h32; vals[1] = 8'h1D; vals[2] = 8'h3D;

      // reset state
      @(negedge clk);
      model_reset();
      check_all("reset");
      rst = 1'b1;

      // three writes, three reads in order
      for (int i = 0; i < 3; i++) step("wr3", 1'b1, 1'b0, 1'b0, vals[i]);
      check("wr3.count3", 32'(fifo_counter), 3);
      check("wr3.ae", 32'(almost_empty), 1);
`ifdef FIFO_FWFT_EN
      check("fwft.head_before_read", 32'(buf_out), 32'h32);
`else
      check("reg.out_before_read", 32'(buf_out), 0);
`endif
      for (int i = 0; i < 3; i++) begin
         step("rd3", 1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
         check("rd3.order", 32'(buf_out), 32'(vals[i]));
`endif
      end
      check("rd3.empty", 32'(buf_empty), 1);

      // fill to full, then overflow
      for (int i = 0; i < 64; i++) begin
         step("fill", 1'b1, 1'b0, 1'b0, 8'(i));
         check("fill.af_edge", 32'(almost_full), 32'(i + 1 >= 60));
      end
      check("fill.full", 32'(buf_full), 1);
      check("fill.count64", 32'(fifo_counter), 64);
      step("ovf", 1'b1, 1'b0, 1'b0, 8'hEE);
      check("ovf.flag", 32'(overflow), 1);
      check("ovf.count", 32'(fifo_counter), 64);

      // full with simultaneous read/write: count holds, 0..9 emerge
      for (int i = 0; i < 10; i++) begin
`ifdef FIFO_FWFT_EN
         check("wrap.head", 32'(buf_out), 32'(i));
`endif
         step("wrap", 1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
`ifndef FIFO_FWFT_EN
         check("wrap.seq", 32'(buf_out), 32'(i));
`endif
         check("wrap.count", 32'(fifo_counter), 64);
      end

      // flush with all requests active: clr wins
      step("clr_prio", 1'b1, 1'b1, 1'b1, 8'h55);
      check("clr_prio.count", 32'(fifo_counter), 0);
      check("clr_prio.ovf", 32'(overflow), 0);

      // underflow on empty; write+read on empty writes only
      step("unf", 1'b0, 1'b1, 1'b0, 8'h00);
      check("unf.flag", 32'(underflow), 1);
      step("unf_wr", 1'b1, 1'b1, 1'b0, 8'hA7);
      check("unf_wr.count", 32'(fifo_counter), 1);
      step("clr2", 1'b0, 1'b0, 1'b1, 8'h00);

      // randomized traffic: write-heavy then read-heavy
      for (int i = 0; i < 400; i++) begin
         logic w, r, c;
         if (i < 200) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         c = ($urandom_range(0, 63) == 0);
         step("rand", w, r, c, 8'($urandom));
      end

      // asynchronous reset in the middle of a burst at count 20
      step("pre", 1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 20; i++) step("burst", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      check("burst.count20", 32'(fifo_counter), 20);
      wr_en = 1'b1; buf_in = 8'hC3;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      wr_en = 1'b0;
      @(negedge clk);
      check_all("rst_hold");
      rst = 1'b1;

      // first request after release honoured; then flush clears sticky flags
      step("post_unf", 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) step("post_wr", 1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
      check("post_wr.count5", 32'(fifo_counter), 5);
      step("final_clr", 1'b0, 1'b0, 1'b1, 8'h00);
      check("final_clr.count", 32'(fifo_counter), 0);
      check("final_clr.unf", 32'(underflow), 0);
      check("final_clr.ovf", 32'(overflow), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
